// File: rtl/encrypt_pipe_rot_lanes.sv
// rtl/encrypt_pipe_rot_lanes.sv - elastic two-stage per-lane Caesar rotation with rolling key offset
module encrypt_pipe_rot_lanes #(
   parameter int LANES    = 1,
   parameter int FREQ_W   = 3,
   parameter int ROT_STEP = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [4:0]         cfg_shift,
   input  logic [FREQ_W-1:0]  cfg_rot_freq,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic               in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic [LANES-1:0]   out_is_alpha
);
   localparam logic [5:0] STEP6 = 6'(ROT_STEP);

   logic [4:0]         shift_q;
   logic [4:0]         offset_q;
   logic [FREQ_W-1:0]  rot_freq_q;
   logic [FREQ_W-1:0]  beat_cnt_q;

   logic               s1_valid;
   logic               s1_mode;
   logic [4:0]         s1_eff;
   logic [LANES-1:0]   s1_alpha;
   logic [LANES-1:0]   s1_upper;
   logic [5*LANES-1:0] s1_idx;
   logic [8*LANES-1:0] s1_raw;

   logic               s1_adv;
   logic               accept;
   logic               roll;
   logic [5:0]         eff_sum;
   logic [5:0]         eff_next;
   logic [5:0]         off_sum;
   logic [5:0]         off_next;

   logic [LANES-1:0]   c_upper;
   logic [LANES-1:0]   c_lower;
   logic [LANES-1:0]   c_alpha;
   logic [5*LANES-1:0] c_idx;

   logic [5:0]         dstep;
   logic [5:0]         lsum;
   logic [5:0]         lidx;
   logic [7:0]         lbase;
   logic [8*LANES-1:0] rot_data;

   assign s1_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s1_adv;
   assign accept   = in_valid && in_ready;

   // Both operands stay below 26, so one conditional subtract is a full mod 26
   always_comb begin
      eff_sum  = {1'b0, shift_q} + {1'b0, offset_q};
      eff_next = (eff_sum >= 6'd26) ? eff_sum - 6'd26 : eff_sum;
      off_sum  = {1'b0, offset_q} + STEP6;
      off_next = (off_sum >= 6'd26) ? off_sum - 6'd26 : off_sum;
      roll     = (rot_freq_q != '0) && (beat_cnt_q == rot_freq_q - FREQ_W'(1));
   end

   always_comb begin
      c_upper = '0;
      c_lower = '0;
      c_alpha = '0;
      c_idx   = '0;
      for (int i = 0; i < LANES; i++) begin
         c_upper[i] = (in_data[8*i +: 8] >= 8'd65) && (in_data[8*i +: 8] <= 8'd90);
         c_lower[i] = (in_data[8*i +: 8] >= 8'd97) && (in_data[8*i +: 8] <= 8'd122);
         c_alpha[i] = c_upper[i] || c_lower[i];
         c_idx[5*i +: 5] = c_upper[i] ? 5'(in_data[8*i +: 8] - 8'd65)
                                      : 5'(in_data[8*i +: 8] - 8'd97);
      end
   end

   // Decrypt adds 26-eff so both directions share the same adder and subtract
   always_comb begin
      dstep    = s1_mode ? {1'b0, s1_eff} : 6'd26 - {1'b0, s1_eff};
      lsum     = '0;
      lidx     = '0;
      lbase    = '0;
      rot_data = '0;
      for (int i = 0; i < LANES; i++) begin
         lsum  = {1'b0, s1_idx[5*i +: 5]} + dstep;
         lidx  = (lsum >= 6'd26) ? lsum - 6'd26 : lsum;
         lbase = s1_upper[i] ? 8'd65 : 8'd97;
         rot_data[8*i +: 8] = s1_alpha[i] ? lbase + {2'b00, lidx} : s1_raw[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q      <= '0;
         offset_q     <= '0;
         rot_freq_q   <= '0;
         beat_cnt_q   <= '0;
         s1_valid     <= 1'b0;
         s1_mode      <= 1'b0;
         s1_eff       <= '0;
         s1_alpha     <= '0;
         s1_upper     <= '0;
         s1_idx       <= '0;
         s1_raw       <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_is_alpha <= '0;
      end else begin
         // A load wins over the roll so a same-cycle beat never advances the new key state
         if (cfg_load) begin
            shift_q    <= (cfg_shift >= 5'd26) ? cfg_shift - 5'd26 : cfg_shift;
            rot_freq_q <= cfg_rot_freq;
            offset_q   <= '0;
            beat_cnt_q <= '0;
         end else if (accept) begin
            if (roll) begin
               offset_q   <= off_next[4:0];
               beat_cnt_q <= '0;
            end else begin
               beat_cnt_q <= beat_cnt_q + FREQ_W'(1);
            end
         end

         if (accept) begin
            s1_valid <= 1'b1;
            s1_mode  <= in_mode;
            s1_eff   <= eff_next[4:0];
            s1_alpha <= c_alpha;
            s1_upper <= c_upper;
            s1_idx   <= c_idx;
            s1_raw   <= in_data;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data     <= rot_data;
               out_is_alpha <= s1_alpha;
            end
         end
      end
   end
endmodule
